// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t : controller states
//     IDLE : waiting for an operation
//     RUN  : adding one chunk per cycle
//     DONE : holding the result
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
//   in_valid/in_ready   : operation handshake carrying a, b, cin, sub
//   out_valid/out_ready : result handshake carrying sum, cout, ovf
// master = the side issuing operations, slave = the adder.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/digit_serial_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder.
//   a, b  : chunk operands
//   cin   : carry into bit 0
//   s     : chunk sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for overflow detection)
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Ripple in a procedural loop so the carry chain is a single variable
    // rather than a self-referencing vector.
    always_comb begin
        logic carry;
        s     = '0;
        c_msb = 1'b0;
        carry = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// producing a WIDTH-bit result NCHUNK cycles after an operation is accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of digit_serial_adder_if
//           (a, b, cin, sub in; sum, cout, ovf out; valid/ready on each side)
// sub=1 computes a + ~b + 1; cout=1 then means "no borrow".
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = $clog2(NCHUNK) + 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
        $error("digit_serial_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, sum_reg, sum_next;
    logic              carry_reg, sub_reg, cout_reg, ovf_reg;
    logic [IDXW-1:0]   idx_reg;

    logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
    logic              chunk_cout, chunk_cmsb;
    logic              last_chunk;
    logic              accept;

    // The operation type is kept alongside the operands for observability;
    // the datapath itself only needs the pre-inverted b and the carry.
    logic              unused_sub;
    assign unused_sub = sub_reg;

    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign last_chunk = (idx_reg == IDXW'(NCHUNK - 1));

    // Chunk operand select and result merge, driven by the chunk index.
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        sum_next = sum_reg;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_chunk                    = a_reg[i*CHUNK +: CHUNK];
                b_chunk                    = b_reg[i*CHUNK +: CHUNK];
                sum_next[i*CHUNK +: CHUNK] = s_chunk;
            end
        end
    end

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_reg),
        .s     (s_chunk),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_chunk)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
            sub_reg   <= bus.sub;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= chunk_cout;
            idx_reg   <= idx_reg + 1'b1;
            if (last_chunk) begin
                cout_reg <= chunk_cout;
                ovf_reg  <= chunk_cmsb ^ chunk_cout;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

endmodule
